// File: rtl/rca_lsu_port.sv
// rtl/rca_lsu_port.sv - RCA load/store request responder on the core data-memory port
module rca_lsu_port #(
    parameter int XLEN            = 32,
    parameter int TAG_W           = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rca_req_valid,
    output logic             rca_req_ready,
    input  logic [XLEN-1:0]  rca_req_addr,
    input  logic [XLEN-1:0]  rca_req_wdata,
    input  logic             rca_req_store,
    input  logic [2:0]       rca_req_fn3,
    input  logic [TAG_W-1:0] rca_req_tag,
    output logic             rca_rsp_valid,
    input  logic             rca_rsp_ready,
    output logic [XLEN-1:0]  rca_rsp_data,
    output logic [TAG_W-1:0] rca_rsp_tag,
    output logic             rca_rsp_err,
    input  logic             cpu_lsu_busy,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [XLEN-1:0]  mem_addr,
    output logic             mem_we,
    output logic [3:0]       mem_be,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             rca_lsu_idle
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = PW + 2;
    localparam logic [CW-1:0] CMAX = CW'(MAX_OUTSTANDING);

    typedef enum logic {S_EMPTY, S_HELD} state_t;

    state_t            r_state;
    logic              r_store, r_err;
    logic [XLEN-1:0]   r_addr, r_wdata;
    logic [2:0]        r_fn3;
    logic [TAG_W-1:0]  r_tag;
    logic [3:0]        r_be;

    logic [CW-1:0]     r_if_cnt, r_rsp_cnt;
    logic [PW-1:0]     r_if_wr, r_if_rd, r_rsp_wr, r_rsp_rd;
    logic [2:0]        r_if_fn3 [MAX_OUTSTANDING];
    logic [1:0]        r_if_off [MAX_OUTSTANDING];
    logic [TAG_W-1:0]  r_if_tag [MAX_OUTSTANDING];
    logic [XLEN-1:0]   r_rsp_data [MAX_OUTSTANDING];
    logic [TAG_W-1:0]  r_rsp_tag  [MAX_OUTSTANDING];
    logic              r_rsp_err  [MAX_OUTSTANDING];

    logic [3:0]        w_in_be;
    logic [XLEN-1:0]   w_in_wdata;
    logic              w_in_err;
    logic [CW-1:0]     w_used;
    logic              w_held, w_mem_fire, w_err_retire, w_retire, w_accept;
    logic              w_if_push, w_if_pop, w_rsp_push, w_rsp_pop;
    logic [2:0]        w_pop_fn3;
    logic [1:0]        w_pop_off;
    logic [TAG_W-1:0]  w_pop_tag;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [XLEN-1:0]   w_load_data;

    // Decode the incoming request: lane enables, replicated store data, error
    always_comb begin
        w_in_be    = 4'b0000;
        w_in_wdata = rca_req_wdata;
        w_in_err   = 1'b0;
        case (rca_req_fn3)
            3'b000, 3'b100: begin
                w_in_be    = 4'b0001 << rca_req_addr[1:0];
                w_in_wdata = {4{rca_req_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                w_in_be    = 4'b0011 << rca_req_addr[1:0];
                w_in_wdata = {2{rca_req_wdata[15:0]}};
                w_in_err   = rca_req_addr[0];
            end
            3'b010: begin
                w_in_be  = 4'b1111;
                w_in_err = |rca_req_addr[1:0];
            end
            default: w_in_err = 1'b1;
        endcase
    end

    // Loads only issue while a response slot is guaranteed for their data
    assign w_used        = r_if_cnt + r_rsp_cnt;
    assign w_held        = (r_state == S_HELD);
    assign mem_req_valid = w_held && !r_err && !cpu_lsu_busy && (r_store || (w_used < CMAX));
    assign w_mem_fire    = mem_req_valid && mem_req_ready;
    // Errors wait for older loads to drain so responses stay in request order
    assign w_err_retire  = w_held && r_err && (r_if_cnt == '0) && (r_rsp_cnt != CMAX);
    assign w_retire      = w_mem_fire || w_err_retire;
    assign rca_req_ready = !w_held || w_retire;
    assign w_accept      = rca_req_valid && rca_req_ready;

    assign mem_addr  = {r_addr[XLEN-1:2], 2'b00};
    assign mem_we    = r_store;
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;

    // Single-entry request register; fields hold after retire until the next accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_store <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_fn3   <= 3'b000;
            r_tag   <= '0;
            r_be    <= 4'b0000;
        end else if (w_accept) begin
            r_state <= S_HELD;
            r_store <= rca_req_store;
            r_err   <= w_in_err;
            r_addr  <= rca_req_addr;
            r_wdata <= w_in_wdata;
            r_fn3   <= rca_req_fn3;
            r_tag   <= rca_req_tag;
            r_be    <= w_in_be;
        end else if (w_retire) begin
            r_state <= S_EMPTY;
        end
    end

    assign w_if_push = w_mem_fire && !r_store;
    assign w_if_pop  = mem_rvalid && (r_if_cnt != '0);
    assign w_pop_fn3 = r_if_fn3[r_if_rd];
    assign w_pop_off = r_if_off[r_if_rd];
    assign w_pop_tag = r_if_tag[r_if_rd];
    assign w_byte    = mem_rdata[{w_pop_off, 3'b000} +: 8];
    assign w_half    = mem_rdata[{w_pop_off[1], 4'b0000} +: 16];

    // Extract and extend the addressed field of the returned word
    always_comb begin
        w_load_data = mem_rdata;
        case (w_pop_fn3)
            3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
            3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    // In-flight load bookkeeping: pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_wr  <= '0;
            r_if_rd  <= '0;
            r_if_cnt <= '0;
        end else begin
            if (w_if_push) r_if_wr <= r_if_wr + 1'b1;
            if (w_if_pop)  r_if_rd <= r_if_rd + 1'b1;
            r_if_cnt <= r_if_cnt + CW'(w_if_push) - CW'(w_if_pop);
        end
    end

    // In-flight load storage: extraction info and tag per issued load
    always_ff @(posedge clk) begin
        if (w_if_push) begin
            r_if_fn3[r_if_wr] <= r_fn3;
            r_if_off[r_if_wr] <= r_addr[1:0];
            r_if_tag[r_if_wr] <= r_tag;
        end
    end

    assign w_rsp_push    = w_if_pop || w_err_retire;
    assign rca_rsp_valid = (r_rsp_cnt != '0);
    assign w_rsp_pop     = rca_rsp_valid && rca_rsp_ready;
    assign rca_rsp_data  = rca_rsp_valid ? r_rsp_data[r_rsp_rd] : '0;
    assign rca_rsp_tag   = rca_rsp_valid ? r_rsp_tag[r_rsp_rd] : '0;
    assign rca_rsp_err   = rca_rsp_valid && r_rsp_err[r_rsp_rd];
    assign rca_lsu_idle  = !w_held && (r_if_cnt == '0) && (r_rsp_cnt == '0);

    // Response FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_wr  <= '0;
            r_rsp_rd  <= '0;
            r_rsp_cnt <= '0;
        end else begin
            if (w_rsp_push) r_rsp_wr <= r_rsp_wr + 1'b1;
            if (w_rsp_pop)  r_rsp_rd <= r_rsp_rd + 1'b1;
            r_rsp_cnt <= r_rsp_cnt + CW'(w_rsp_push) - CW'(w_rsp_pop);
        end
    end

    // Response FIFO storage; an error push carries zero data
    always_ff @(posedge clk) begin
        if (w_rsp_push) begin
            r_rsp_data[r_rsp_wr] <= w_if_pop ? w_load_data : '0;
            r_rsp_tag[r_rsp_wr]  <= w_if_pop ? w_pop_tag : r_tag;
            r_rsp_err[r_rsp_wr]  <= !w_if_pop;
        end
    end
endmodule
